serial_parity_checker: RTL

Receive-side companion to the team's even-parity generator. Accepts a serial stream of DATA_WIDTH data bits (LSB first) followed by one even-parity bit. Reassembles the data word and flags any parity mismatch. Sits after a bit-level link or deserializer front end and hands checked words plus an error flag to downstream logic.

---
 rtl/parity_pkg.sv | 14 +
 rtl/serial_parity_checker.sv | 121 ++++++++++++
 2 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the even-parity generator and checker pair.
// Holds the frame FSM states, default data width and error-counter width.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } parity_state_e;

  localparam int PARITY_DATA_WIDTH_DEFAULT = 8;
  localparam int ERR_CNT_W                 = 8;

endpackage

// File: rtl/serial_parity_checker.sv
// Serial even-parity checker: LSB-first data bits then a parity bit; out_valid 1 cycle after the parity bit.
// No backpressure; bit_valid low stalls a frame. PARITY_ERR_CNT_EN enables the saturating err_cnt.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_WIDTH = PARITY_DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  bit_sof,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  parity_err,
  output logic                  frame_abort,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  parity_state_e         state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  acc_q, acc_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  vld_q, vld_d;
  logic                  abort_q, abort_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    err_d   = err_q;
    vld_d   = 1'b0;
    abort_d = 1'b0;
    if (bit_valid) begin
      if (bit_sof) begin
        // A start bit always opens a new frame, even where a parity bit was due.
        abort_d    = (state_q != IDLE);
        shreg_d    = '0;
        shreg_d[0] = bit_in;
        idx_d      = IDX_W'(1);
        acc_d      = bit_in;
        state_d    = DATA;
      end else begin
        unique case (state_q)
          DATA: begin
            shreg_d[idx_q] = bit_in;
            acc_d          = acc_q ^ bit_in;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = PARITY;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
          PARITY: begin
            data_d  = shreg_q;
            err_d   = acc_q ^ bit_in;
            vld_d   = 1'b1;
            acc_d   = 1'b0;
            state_d = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= 1'b0;
      shreg_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      abort_q <= abort_d;
    end
  end

  assign data_out    = data_q;
  assign parity_err  = err_q;
  assign out_valid   = vld_q;
  assign frame_abort = abort_q;

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // Counted alongside the result so err_cnt already includes it while out_valid is high.
  always_comb begin
    cnt_d = cnt_q;
    if (vld_d && err_d && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule
